// File: rtl/cmd_tx_streamer.sv
// Streams a stored frame template to GMII, appending CRC-32 FCS and an IFG.
// Template words: bit8 marks in-frame bytes; the first word with bit8=0 ends the frame.
module cmd_tx_streamer #(
  parameter int IFG_BYTES = 12,
  parameter int HDR_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        slot,
  output logic        busy,
  output logic        done,
  output logic        mem_ce,
  output logic        mem_oce,
  output logic [10:0] mem_adr,
  input  logic [8:0]  mem_dout,
  output logic [7:0]  gtx_d,
  output logic        gtx_en
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    DATA,
    FCS,
    IFG
  } state_e;

  localparam logic [15:0] IFG_END = 16'(IFG_BYTES);
  localparam logic [9:0]  HDR_N   = 10'(HDR_BYTES);

  state_e      state_q, state_d;
  logic [10:0] adr_q, adr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  fcs_q, fcs_d;
  logic [15:0] ifg_q, ifg_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic [31:0] fcs_w;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign fcs_w = ~crc_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    fcs_d   = fcs_q;
    ifg_d   = ifg_q;
    crc_d   = crc_q;
    txd_d   = 8'd0;
    txen_d  = 1'b0;
    mem_ce  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d   = {slot, 10'd0};
          cnt_d   = 10'd0;
          crc_d   = 32'hFFFF_FFFF;
          state_d = PRIME;
        end
      end
      PRIME: begin
        mem_ce  = 1'b1;
        adr_d   = adr_q + 11'd1;
        state_d = DATA;
      end
      DATA: begin
        mem_ce = 1'b1;
        // Hold at the last word of the slot so reads never cross slots.
        if (adr_q[9:0] != 10'h3FF)
          adr_d = adr_q + 11'd1;
        if (mem_dout[8]) begin
          txen_d = 1'b1;
          txd_d  = mem_dout[7:0];
          cnt_d  = cnt_q + 10'd1;
          if (cnt_q >= HDR_N)
            crc_d = crc_byte(crc_q, mem_dout[7:0]);
          if (cnt_q == 10'h3FF) begin
            fcs_d   = 2'd0;
            state_d = FCS;
          end
        end else if (cnt_q == 10'd0) begin
          ifg_d   = IFG_END;
          state_d = IFG;
        end else begin
          // First FCS byte goes out here so it follows the data gaplessly.
          txen_d  = 1'b1;
          txd_d   = fcs_w[7:0];
          fcs_d   = 2'd1;
          state_d = FCS;
        end
      end
      FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs_w[{fcs_q, 3'b000} +: 8];
        fcs_d  = fcs_q + 2'd1;
        if (fcs_q == 2'd3) begin
          ifg_d   = 16'd0;
          state_d = IFG;
        end
      end
      IFG: begin
        if (ifg_q == IFG_END)
          state_d = IDLE;
        else
          ifg_d = ifg_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      adr_q   <= 11'd0;
      cnt_q   <= 10'd0;
      fcs_q   <= 2'd0;
      ifg_q   <= 16'd0;
      crc_q   <= 32'hFFFF_FFFF;
      txd_q   <= 8'd0;
      txen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      fcs_q   <= fcs_d;
      ifg_q   <= ifg_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == IFG) && (ifg_q == IFG_END);
  assign mem_oce = 1'b1;
  assign mem_adr = adr_q;
  assign gtx_d   = txd_q;
  assign gtx_en  = txen_q;

endmodule

// File: tb/tb_cmd_tx_streamer.sv
// Scoreboard bench for cmd_tx_streamer: expected bytes queued at start,
// a negedge monitor pops and compares every transmitted byte.
module tb_cmd_tx_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        slot = 1'b0;
  logic        busy, done, mem_ce, mem_oce, gtx_en;
  logic [10:0] mem_adr;
  logic [8:0]  mem_dout;
  logic [7:0]  gtx_d;

  cmd_tx_streamer dut (
    .clk(clk), .reset(reset), .start(start), .slot(slot),
    .busy(busy), .done(done), .mem_ce(mem_ce), .mem_oce(mem_oce),
    .mem_adr(mem_adr), .mem_dout(mem_dout),
    .gtx_d(gtx_d), .gtx_en(gtx_en)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [0:2047];
  always @(posedge clk) if (mem_ce) mem_dout <= mem[mem_adr];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int gap_q [$];
  int done_cnt = 0;
  int byte_cnt = 0;
  int gap = 0;
  int g_exp;
  bit track_adr = 0;
  int max_adr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (gtx_en) begin
        gap = 0;
        byte_cnt++;
        if (exp_q.size() == 0) fail("extra_byte");
        else chk("gtx_d", 32'(gtx_d), 32'(exp_q.pop_front()));
      end else begin
        gap++;
        chk("idle_d_zero", 32'(gtx_d), 32'd0);
      end
      if (done) begin
        done_cnt++;
        if (gap_q.size() == 0) fail("unexpected_done");
        else begin
          g_exp = gap_q.pop_front();
          if (g_exp >= 0) chk("ifg_gap", gap, g_exp);
        end
      end
    end
  end

  always @(posedge clk)
    if (track_adr && mem_ce && 32'(mem_adr) > max_adr)
      max_adr = 32'(mem_adr);

  task automatic load_tpl(input int base, input bit alt);
    for (int i = 0; i < 1024; i++) mem[11'(base + i)] = 9'h000;
    for (int i = 0; i < 7; i++) mem[11'(base + i)] = 9'h155;
    mem[11'(base + 7)] = 9'h1D5;
    for (int i = 0; i < 30; i++)
      mem[11'(base + 8 + i)] = {1'b1, 8'(i * 13 + 1)};
    if (alt) begin
      mem[11'(base + 11)] = 9'h1F0;
      mem[11'(base + 25)] = 9'h10F;
    end
  endtask

  task automatic push_frame(input int base);
    logic [31:0] c;
    logic [8:0] w;
    int n;
    c = 32'hFFFF_FFFF;
    n = 0;
    while (n < 1024) begin
      w = mem[11'(base + n)];
      if (!w[8]) break;
      exp_q.push_back(w[7:0]);
      if (n >= 8) c = crc_upd(c, w[7:0]);
      n++;
    end
    if (n > 0) begin
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
      gap_q.push_back(12);
    end else gap_q.push_back(-1);
  endtask

  // Cycle 0 is the cycle in which start is high; returns the cycle of first gtx_en.
  task automatic send(input bit s, output int lat);
    @(negedge clk);
    slot = s;
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (gtx_en) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 4000; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (k == 4000) fail(nm);
  endtask

  task automatic chk_reset_outs();
    chk("rst_gtx_en", 32'(gtx_en), 32'd0);
    chk("rst_gtx_d", 32'(gtx_d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_mem_oce", 32'(mem_oce), 32'd1);
    chk("rst_mem_adr", 32'(mem_adr), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat, d0, b0, k;
    string s;
    logic [31:0] c;

    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
    load_tpl(0, 1'b0);
    load_tpl(1024, 1'b1);

    s = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < s.len(); i++) c = crc_upd(c, s[i]);
    chk("crc_ref_check", ~c, 32'hCBF4_3926);

    repeat (3) @(negedge clk);
    chk_reset_outs();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // slot 0 template
    push_frame(0);
    d0 = done_cnt;
    send(1'b0, lat);
    chk("s0_latency", lat, 3);
    wait_idle("s0_timeout");
    chk("s0_done", done_cnt - d0, 1);
    chk("s0_drained", exp_q.size(), 0);

    // slot 1 template
    push_frame(1024);
    d0 = done_cnt;
    send(1'b1, lat);
    chk("s1_latency", lat, 3);
    wait_idle("s1_timeout");
    chk("s1_done", done_cnt - d0, 1);
    chk("s1_drained", exp_q.size(), 0);

    // second start while busy is ignored
    push_frame(0);
    d0 = done_cnt;
    send(1'b0, lat);
    repeat (5) @(negedge clk);
    slot = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("dbl_timeout");
    repeat (20) @(negedge clk);
    chk("dbl_done", done_cnt - d0, 1);
    chk("dbl_busy", 32'(busy), 32'd0);
    chk("dbl_drained", exp_q.size(), 0);

    // empty frame
    mem[0] = 9'h000;
    push_frame(0);
    d0 = done_cnt;
    @(negedge clk);
    slot = 1'b0;
    start = 1'b1;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (!busy) break;
    end
    chk("empty_busy_within4", 32'(k <= 4), 32'd1);
    repeat (3) @(negedge clk);
    chk("empty_done", done_cnt - d0, 1);
    load_tpl(0, 1'b0);

    // full slot 0
    for (int i = 0; i < 1024; i++) mem[i] = {1'b1, 8'(i * 5 + 7)};
    push_frame(0);
    d0 = done_cnt;
    max_adr = 0;
    track_adr = 1;
    send(1'b0, lat);
    wait_idle("full_timeout");
    track_adr = 0;
    chk("full_max_adr", max_adr, 1023);
    chk("full_done", done_cnt - d0, 1);
    chk("full_drained", exp_q.size(), 0);
    load_tpl(0, 1'b0);

    // reset in mid-frame
    push_frame(0);
    b0 = byte_cnt;
    send(1'b0, lat);
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (byte_cnt - b0 >= 20) break;
    end
    if (k == 200) fail("rst_wait_timeout");
    #2 reset = 1'b1;
    #1 chk("rst_async_en", 32'(gtx_en), 32'd0);
    exp_q.delete();
    gap_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);

    push_frame(0);
    d0 = done_cnt;
    send(1'b0, lat);
    chk("post_rst_latency", lat, 3);
    wait_idle("post_rst_timeout");
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
